// File: rtl/fetch_predict.sv
// Fetch stage of a Y86-64 style pipeline: decodes the ten bytes at f_PC,
// predicts the next PC and holds the F (predicted PC) and D pipeline registers.
module fetch_predict (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] f_PC,
  input  logic [79:0] instr,
  input  logic        imem_error,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_LAST  = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_instr_valid;
  logic        w_need_regids;
  logic        w_need_valC;
  logic [3:0]  w_rA;
  logic [3:0]  w_rB;
  logic [63:0] w_valC;
  logic [63:0] w_valP;
  logic [3:0]  w_stat;
  logic [63:0] w_predPC;

  logic [63:0] r_predPC;
  logic [3:0]  r_stat;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_rA;
  logic [3:0]  r_rB;
  logic [63:0] r_valC;
  logic [63:0] r_valP;

  // A bad fetch address is turned into a nop so nothing downstream acts on garbage.
  assign w_icode       = imem_error ? I_NOP : instr[7:4];
  assign w_ifun        = imem_error ? 4'h0  : instr[3:0];
  assign w_instr_valid = (w_icode <= I_LAST);

  always_comb begin
    w_need_regids = 1'b0;
    w_need_valC   = 1'b0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: w_need_regids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        w_need_regids = 1'b1;
        w_need_valC   = 1'b1;
      end
      4'h7, 4'h8: w_need_valC = 1'b1;
      default: begin
        w_need_regids = 1'b0;
        w_need_valC   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rA   = REG_NONE;
    w_rB   = REG_NONE;
    w_valC = 64'd0;
    if (w_need_regids) begin
      w_rA = instr[15:12];
      w_rB = instr[11:8];
    end
    if (w_need_valC) begin
      w_valC = w_need_regids ? instr[79:16] : instr[71:8];
    end
  end

  // Invalid icodes decode with no register or constant bytes, so length is 1.
  assign w_valP = f_PC + 64'd1 + {63'd0, w_need_regids} +
                  (w_need_valC ? 64'd8 : 64'd0);

  always_comb begin
    w_stat = STAT_AOK;
    if (imem_error)         w_stat = STAT_ADR;
    else if (!w_instr_valid) w_stat = STAT_INS;
    else if (w_icode == I_HALT) w_stat = STAT_HLT;
  end

  // Jumps are always predicted taken; ret falls through and is fixed up by the PC-select mux.
  assign w_predPC = ((w_icode == I_JXX) || (w_icode == I_CALL)) ? w_valC : w_valP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_predPC <= 64'd0;
    end else if (!F_stall) begin
      r_predPC <= w_predPC;
    end
  end

  // Stall has priority over bubble; reset overrides both.
  always_ff @(posedge clk) begin
    if (!rst_n || (D_bubble && !D_stall)) begin
      r_stat  <= STAT_AOK;
      r_icode <= I_NOP;
      r_ifun  <= 4'h0;
      r_rA    <= REG_NONE;
      r_rB    <= REG_NONE;
      r_valC  <= 64'd0;
      r_valP  <= 64'd0;
    end else if (!D_stall) begin
      r_stat  <= w_stat;
      r_icode <= w_icode;
      r_ifun  <= w_ifun;
      r_rA    <= w_rA;
      r_rB    <= w_rB;
      r_valC  <= w_valC;
      r_valP  <= w_valP;
    end
  end

  assign F_predPC = r_predPC;
  assign D_stat   = r_stat;
  assign D_icode  = r_icode;
  assign D_ifun   = r_ifun;
  assign D_rA     = r_rA;
  assign D_rB     = r_rB;
  assign D_valC   = r_valC;
  assign D_valP   = r_valP;

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed cases plus randomized traffic against a
// table-driven instruction-length reference model.
module tb_fetch_predict;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_PC;
  logic [79:0] instr;
  logic        imem_error;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [63:0] F_predPC;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } dreg_t;

  dreg_t       m_d;
  logic [63:0] m_pred;

  // Bytes per instruction, indexed by icode; 0 marks an invalid opcode.
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  fetch_predict dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_PC       (f_PC),
    .instr      (instr),
    .imem_error (imem_error),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .F_predPC   (F_predPC),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic dreg_t nop_state();
    dreg_t d;
    d = '{stat: 4'd1, icode: 4'd1, ifun: 4'd0, rA: 4'hF, rB: 4'hF, valC: 64'd0, valP: 64'd0};
    return d;
  endfunction

  // Reference: derive length from the opcode table, then pull fields out of the byte stream.
  function automatic void model_fetch(input logic [63:0] pc, input logic [79:0] ins,
                                      input logic err, output dreg_t d, output logic [63:0] pred);
    logic [7:0] b [10];
    int len, off;
    for (int i = 0; i < 10; i++) b[i] = ins[8*i +: 8];
    d.icode = err ? 4'd1 : b[0][7:4];
    d.ifun  = err ? 4'd0 : b[0][3:0];
    len = len_tab[d.icode];
    if (err)              d.stat = 4'd3;
    else if (len == 0)    d.stat = 4'd4;
    else if (d.icode == 0) d.stat = 4'd2;
    else                  d.stat = 4'd1;
    if (len == 0) len = 1;
    d.rA = 4'hF;
    d.rB = 4'hF;
    if (len == 2 || len == 10) begin
      d.rA = b[1][7:4];
      d.rB = b[1][3:0];
    end
    d.valC = 64'd0;
    if (len >= 9) begin
      off = len - 8;
      for (int i = 0; i < 8; i++) d.valC = d.valC | (64'(b[off + i]) << (8 * i));
    end
    d.valP = pc + 64'(len);
    pred = (d.icode == 4'd7 || d.icode == 4'd8) ? d.valC : d.valP;
  endfunction

  task automatic step(input logic [63:0] pc, input logic [79:0] ins, input logic err,
                      input logic fs, input logic ds, input logic db, input logic rn);
    dreg_t       fd;
    logic [63:0] fp;
    f_PC = pc; instr = ins; imem_error = err;
    F_stall = fs; D_stall = ds; D_bubble = db; rst_n = rn;
    model_fetch(pc, ins, err, fd, fp);
    if (!rn) begin
      m_pred = 64'd0;
      m_d    = nop_state();
    end else begin
      if (!fs) m_pred = fp;
      if (!ds) m_d = db ? nop_state() : fd;
    end
    @(posedge clk);
    #1;
    chk("F_predPC", F_predPC, m_pred);
    chk("D_stat",   64'(D_stat),  64'(m_d.stat));
    chk("D_icode",  64'(D_icode), 64'(m_d.icode));
    chk("D_ifun",   64'(D_ifun),  64'(m_d.ifun));
    chk("D_rA",     64'(D_rA),    64'(m_d.rA));
    chk("D_rB",     64'(D_rB),    64'(m_d.rB));
    chk("D_valC",   D_valC, m_d.valC);
    chk("D_valP",   D_valP, m_d.valP);
  endtask

  function automatic logic [79:0] rnd_instr();
    logic [79:0] v;
    v = {$urandom, $urandom, $urandom};
    return v;
  endfunction

  initial begin
    logic [63:0] pc;
    logic [79:0] ins;
    m_pred = 64'd0;
    m_d    = nop_state();
    @(posedge clk); #1;

    step(64'h0, rnd_instr(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(64'h0, rnd_instr(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_predPC", F_predPC, 64'd0);
    chk("rst_icode",  64'(D_icode), 64'd1);
    chk("rst_stat",   64'(D_stat),  64'd1);
    chk("rst_rA",     64'(D_rA),    64'hF);

    step(64'h100, {64'h0A, 8'hF3, 8'h30}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("irmovq_icode", 64'(D_icode), 64'd3);
    chk("irmovq_rB",    64'(D_rB),    64'd3);
    chk("irmovq_valC",  D_valC,   64'hA);
    chk("irmovq_valP",  D_valP,   64'h10A);
    chk("irmovq_pred",  F_predPC, 64'h10A);

    for (int k = 0; k < 3; k++)
      step(64'h300 + 64'(k), rnd_instr(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stall_pred", F_predPC, 64'h10A);
    chk("stall_valP", D_valP,   64'h10A);
    chk("stall_valC", D_valC,   64'hA);
    step(64'h400, rnd_instr(), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("stallbub_icode", 64'(D_icode), 64'd3);
    step(64'h500, {64'h0A, 8'hF3, 8'h30}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bubble_icode", 64'(D_icode), 64'd1);
    chk("bubble_valP",  D_valP, 64'd0);
    chk("bubble_rA",    64'(D_rA), 64'hF);

    step(64'h20, {8'h00, 64'h80, 8'h74}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jxx_valP", D_valP,   64'h29);
    chk("jxx_pred", F_predPC, 64'h80);
    step(64'h20, {8'h00, 64'h200, 8'h80}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("call_valP", D_valP,   64'h29);
    chk("call_pred", F_predPC, 64'h200);
    step(64'h40, {72'h0, 8'h90}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ret_pred", F_predPC, 64'h41);

    step(64'h50, {72'h0, 8'hC0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ins_stat", 64'(D_stat), 64'd4);
    chk("ins_valP", D_valP, 64'h51);
    step(64'h60, {72'h0, 8'h30}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("adr_stat",  64'(D_stat),  64'd3);
    chk("adr_icode", 64'(D_icode), 64'd1);
    step(64'h70, {72'h0, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hlt_stat", 64'(D_stat), 64'd2);

    step(64'hFFFF_FFFF_FFFF_FFFE, {72'h0, 8'h10}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_valP1", D_valP, 64'hFFFF_FFFF_FFFF_FFFF);
    step(64'hFFFF_FFFF_FFFF_FFFF, {72'h0, 8'h10}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_valP0", D_valP, 64'd0);

    for (int n = 0; n < 600; n++) begin
      pc  = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                        : {$urandom, $urandom};
      ins = rnd_instr();
      step(pc, ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 40) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: f_PC  in  64  selected fetch address, combinational from the PC-select mux; instr  in  80  ten instruction bytes at f_PC, byte0 = instr[7:0]; imem_error  in  1  f_PC is outside instruction memory.
REQ-003 SHALL have ports: F_stall  in  1  hold F register; D_stall  in  1  hold D register; D_bubble  in  1  load nop into D register.
REQ-004 SHALL have ports: F_predPC  out  64  registered predicted next PC, fed back to the PC-select mux.
REQ-005 SHALL have ports: D_stat  out  4; D_icode  out  4; D_ifun  out  4; D_rA  out  4; D_rB  out  4; D_valC  out  64; D_valP  out  64.
REQ-006 SHALL use one clock domain; reset is synchronous and active-low on rst_n.

Function
REQ-007 SHALL decode byte0 as icode = instr[7:4], ifun = instr[3:0]; on imem_error, icode = 1 (nop) and ifun = 0.
REQ-008 SHALL flag instr_valid for icode 0x0-0xB only.
REQ-009 SHALL set need_regids for icode {2,3,4,5,6,A,B} and need_valC for icode {3,4,5,7,8}.
REQ-010 SHALL take rA = byte1[7:4] and rB = byte1[3:0] when need_regids; otherwise rA = rB = 0xF.
REQ-011 SHALL take valC little-endian from bytes 2-9 when need_regids, else bytes 1-8; valC = 0 when !need_valC.
REQ-012 SHALL compute valP = f_PC + 1 + need_regids + 8*need_valC, modulo 2^64 (wrap, no error).
REQ-013 SHALL treat an invalid icode as length 1 (valP = f_PC + 1).
REQ-014 SHALL set f_stat: ADR(3) if imem_error; else INS(4) if !instr_valid; else HLT(2) if icode = 0; else AOK(1). Priority is in that order.
REQ-015 SHALL compute f_predPC = valC for icode 7 (jXX, all conditions, predict taken) and icode 8 (call); otherwise f_predPC = valP.
REQ-016 SHALL load F_predPC <= f_predPC on each rising edge unless F_stall = 1, in which case F_predPC holds.
REQ-017 SHALL load the D register from the fetch fields (f_stat, icode, ifun, rA, rB, valC, valP) on each edge when D_stall = 0 and D_bubble = 0.
REQ-018 SHALL hold all D outputs when D_stall = 1, regardless of D_bubble (stall wins).
REQ-019 SHALL load the nop state when D_bubble = 1 and D_stall = 0: stat 1, icode 1, ifun 0, rA = rB = 0xF, valC = valP = 0.
REQ-020 SHALL register all outputs with a latency of one cycle from f_PC/instr to the D outputs and F_predPC, and no combinational output path.
REQ-021 SHALL compute ret (icode 9) valP = f_PC+1 and predict f_predPC = valP; ret correction is owned by the PC-select mux.

Reset
REQ-022 SHALL, when rst_n = 0 at a rising edge, set F_predPC = 0 and the D register to the nop state of REQ-019, overriding stall and bubble.
REQ-023 SHALL start normal operation at the first edge with rst_n = 1; a reset mid-stream discards the in-flight D contents.

Verification
REQ-024 SHALL pass: reset held 2 cycles, then released -> F_predPC = 0 and D_icode = 1, D_stat = 1, D_rA = D_rB = 0xF.
REQ-025 SHALL pass: f_PC = 0x100, irmovq bytes 30 F3 0A00..00 -> next edge D_icode = 3, D_rB = 3, D_valC = 0xA, D_valP = 0x10A, F_predPC = 0x10A.
REQ-026 SHALL pass: f_PC = 0x20, jXX bytes 74 + valC 0x80 -> D_valP = 0x29, F_predPC = 0x80; with call (80 + valC 0x200) -> F_predPC = 0x200, D_valP = 0x29.
REQ-027 SHALL pass: F_stall = D_stall = 1 for 3 cycles with changing instr -> F_predPC and all D outputs unchanged; D_bubble = 1 with D_stall = 1 -> D unchanged; D_bubble = 1 alone -> D becomes nop.
REQ-028 SHALL pass: byte0 = 0xC0 -> D_stat = 4, D_valP = f_PC + 1; imem_error = 1 -> D_stat = 3, D_icode = 1; byte0 = 0x00 -> D_stat = 2.
REQ-029 SHALL pass: f_PC = 0xFFFF_FFFF_FFFF_FFFE, nop (0x10) -> D_valP = 0xFFFF_FFFF_FFFF_FFFF; f_PC = all-ones, nop -> D_valP = 0 (wrap).
